// File: rtl/dt_pkg.sv
// Shared constants and types for the distance-transform datapath.
package dt_pkg;

  localparam int unsigned IMG_W  = 128;
  localparam int unsigned IMG_H  = 128;
  localparam int unsigned RES_AW = 14;
  localparam int unsigned RES_DW = 8;
  localparam int unsigned STI_AW = 10;

  typedef enum logic [0:0] {
    IDLE,
    LOCKED
  } arb_state_t;

endpackage

// File: rtl/dt_rr_pick.sv
// Combinational round-robin picker: first requester after ptr_i, wrapping.
module dt_rr_pick #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            valid_o
);

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!valid_o && req_i[i] && (i == ((32'(ptr_i) + k) % NREQ))) begin
          valid_o  = 1'b1;
          gnt_o[i] = 1'b1;
          idx_o    = IW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/dt_res_arbiter.sv
// Round-robin arbiter with bounded burst lock for the shared res memory port.
// Optional access/stall counters are built when RES_ARB_STATS_EN is defined.
module dt_res_arbiter
  import dt_pkg::*;
#(
  parameter int unsigned NREQ     = 3,
  parameter int unsigned AW       = RES_AW,
  parameter int unsigned DW       = RES_DW,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic               clk,
  input  logic               reset,
`ifdef RES_ARB_STATS_EN
  input  logic               stat_clr_i,
  output logic [15:0]        stat_grants_o,
  output logic [15:0]        stat_stall_o,
`endif
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ-1:0]    we_i,
  input  logic [NREQ-1:0]    lock_i,
  input  logic [NREQ*AW-1:0] addr_i,
  input  logic [NREQ*DW-1:0] wdata_i,
  output logic [NREQ-1:0]    gnt_o,
  output logic [NREQ-1:0]    rvalid_o,
  output logic [DW-1:0]      rdata_o,
  output logic               res_rd_o,
  output logic               res_wr_o,
  output logic [AW-1:0]      res_addr_o,
  output logic [DW-1:0]      res_do_o,
  input  logic [DW-1:0]      res_di_i
);

  localparam int unsigned IW = $clog2(NREQ);

  arb_state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [7:0]    cnt_q, cnt_d;

  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_valid;

  logic [NREQ-1:0] owner_oh;
  logic            owner_req;
  logic            hold;
  logic            any;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic            sel_we;
  logic            sel_lock;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;

  logic            res_rd_q, res_wr_q;
  logic [AW-1:0]   res_addr_q;
  logic [DW-1:0]   res_do_q;
  logic [NREQ-1:0] cmd_oh_q;
  logic [NREQ-1:0] rvalid_q;
  logic [DW-1:0]   rdata_q;

  dt_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_comb begin
    owner_oh  = '0;
    owner_req = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IW'(i) == owner_q) begin
        owner_oh[i] = 1'b1;
        owner_req   = req_i[i];
      end
    end
  end

  // The locked owner keeps the port while it still asks and has budget left;
  // otherwise fall back to round-robin in the same cycle.
  always_comb begin
    hold    = (state_q == LOCKED) && owner_req && (32'(cnt_q) < MAX_LOCK);
    gnt     = hold ? owner_oh : pick_gnt;
    gnt_idx = hold ? owner_q : pick_idx;
    any     = hold || pick_valid;
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_lock  = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_we    = we_i[i];
        sel_lock  = lock_i[i];
        sel_addr  = addr_i[i*AW +: AW];
        sel_wdata = wdata_i[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d = IDLE;
    owner_d = owner_q;
    cnt_d   = '0;
    ptr_d   = ptr_q;
    if (any) begin
      ptr_d = gnt_idx;
      if (hold) begin
        if (sel_lock && (32'(cnt_q) + 32'd1 < MAX_LOCK)) begin
          state_d = LOCKED;
          cnt_d   = cnt_q + 8'd1;
        end
      end else if (sel_lock && (MAX_LOCK > 1)) begin
        state_d = LOCKED;
        owner_d = gnt_idx;
        cnt_d   = 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NREQ - 1);
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // Address and write data hold their last values across idle cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_rd_q   <= 1'b0;
      res_wr_q   <= 1'b0;
      res_addr_q <= '0;
      res_do_q   <= '0;
      cmd_oh_q   <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
    end else begin
      res_rd_q <= any && !sel_we;
      res_wr_q <= any && sel_we;
      cmd_oh_q <= gnt;
      if (any) begin
        res_addr_q <= sel_addr;
        res_do_q   <= sel_wdata;
      end
      rvalid_q <= res_rd_q ? cmd_oh_q : '0;
      if (res_rd_q) begin
        rdata_q <= res_di_i;
      end
    end
  end

  assign gnt_o      = gnt;
  assign rvalid_o   = rvalid_q;
  assign rdata_o    = rdata_q;
  assign res_rd_o   = res_rd_q;
  assign res_wr_o   = res_wr_q;
  assign res_addr_o = res_addr_q;
  assign res_do_o   = res_do_q;

`ifdef RES_ARB_STATS_EN
  logic [15:0] stat_grants_q;
  logic [15:0] stat_stall_q;
  logic        stall;

  assign stall = |(req_i & ~gnt);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_grants_q <= '0;
      stat_stall_q  <= '0;
    end else if (stat_clr_i) begin
      stat_grants_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      if (any && (stat_grants_q != 16'hFFFF)) begin
        stat_grants_q <= stat_grants_q + 16'd1;
      end
      if (stall && (stat_stall_q != 16'hFFFF)) begin
        stat_stall_q <= stat_stall_q + 16'd1;
      end
    end
  end

  assign stat_grants_o = stat_grants_q;
  assign stat_stall_o  = stat_stall_q;
`endif

endmodule

// File: tb/tb_dt_res_arbiter.sv
// Bench for dt_res_arbiter: vector table for grants, scoreboard for memory commands and reads.
module tb_dt_res_arbiter;

  localparam int unsigned NREQ = 3;
  localparam int unsigned AW   = 14;
  localparam int unsigned DW   = 8;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ-1:0]    we = '0;
  logic [NREQ-1:0]    lock = '0;
  logic [NREQ*AW-1:0] addr = '0;
  logic [NREQ*DW-1:0] wdata = '0;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;
  logic               res_rd;
  logic               res_wr;
  logic [AW-1:0]      res_addr;
  logic [DW-1:0]      res_do;
  logic [DW-1:0]      res_di;
`ifdef RES_ARB_STATS_EN
  logic               stat_clr = 1'b0;
  logic [15:0]        stat_grants;
  logic [15:0]        stat_stall;
`endif

  always #5 clk = ~clk;

  dt_res_arbiter #(
    .NREQ     (NREQ),
    .AW       (AW),
    .DW       (DW),
    .MAX_LOCK (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
`ifdef RES_ARB_STATS_EN
    .stat_clr_i    (stat_clr),
    .stat_grants_o (stat_grants),
    .stat_stall_o  (stat_stall),
`endif
    .req_i         (req),
    .we_i          (we),
    .lock_i        (lock),
    .addr_i        (addr),
    .wdata_i       (wdata),
    .gnt_o         (gnt),
    .rvalid_o      (rvalid),
    .rdata_o       (rdata),
    .res_rd_o      (res_rd),
    .res_wr_o      (res_wr),
    .res_addr_o    (res_addr),
    .res_do_o      (res_do),
    .res_di_i      (res_di)
  );

  // Memory model: preload pattern (mem[130] = 8'h05) overlaid by written bytes.
  function automatic logic [7:0] pre(input logic [13:0] a);
    return a[7:0] ^ 8'h87;
  endfunction

  bit [7:0] wmem  [16384];
  bit       wflag [16384];
  bit [7:0] smem  [16384];
  bit       sflag [16384];

  assign res_di = wflag[res_addr] ? wmem[res_addr] : pre(res_addr);

  always @(posedge clk) begin
    if (res_wr) begin
      wmem[res_addr]  <= res_do;
      wflag[res_addr] <= 1'b1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       rd;
    logic       wr;
    logic [13:0] a;
    logic [7:0] d;
    logic [2:0] oh;
  } cmd_t;

  typedef struct {
    int         cyc;
    logic [2:0] oh;
    logic [7:0] d;
  } rsp_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  cmd_t mc;
  rsp_t mr;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor pops expectations only when the DUT drives a command or a read return.
  always @(negedge clk) begin
    if (reset) begin
      if (rvalid != '0) begin
        if (rsp_q.size() == 0) begin
          check("rvalid_unexpected", 32'(rvalid), 32'd0);
        end else begin
          mr = rsp_q.pop_front();
          check("rvalid_cycle", cyc, mr.cyc);
          check("rvalid_owner", 32'(rvalid), 32'(mr.oh));
          check("rdata", 32'(rdata), 32'(mr.d));
        end
      end
      if (res_rd || res_wr) begin
        if (cmd_q.size() == 0) begin
          check("cmd_unexpected", {30'd0, res_rd, res_wr}, 32'd0);
        end else begin
          mc = cmd_q.pop_front();
          check("cmd_cycle", cyc, mc.cyc);
          check("cmd_strobes", {30'd0, res_rd, res_wr}, {30'd0, mc.rd, mc.wr});
          check("cmd_addr", 32'(res_addr), 32'(mc.a));
          if (mc.wr) check("cmd_wdata", 32'(res_do), 32'(mc.d));
          if (mc.rd) rsp_q.push_back('{cyc + 1, mc.oh, mc.d});
        end
      end
    end
  end

  // Drive one cycle just after a rising edge, check the combinational grant mid-cycle,
  // and queue the memory command the expected grant must produce.
  task automatic step(input string nm, input logic [2:0] rq, input logic [2:0] wv,
                      input logic [2:0] lk, input logic [41:0] ad, input logic [23:0] wd,
                      input logic [2:0] eg);
    cmd_t c;
    req   = rq;
    we    = wv;
    lock  = lk;
    addr  = ad;
    wdata = wd;
    @(negedge clk);
    check(nm, 32'(gnt), 32'(eg));
    for (int i = 0; i < 3; i++) begin
      if (eg[i]) begin
        c.cyc = cyc + 1;
        c.rd  = !wv[i];
        c.wr  = wv[i];
        c.a   = ad[i*14 +: 14];
        c.oh  = eg;
        if (wv[i]) begin
          c.d = wd[i*8 +: 8];
          smem[c.a]  = c.d;
          sflag[c.a] = 1'b1;
        end else begin
          c.d = sflag[c.a] ? smem[c.a] : pre(c.a);
        end
        cmd_q.push_back(c);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step("idle_gnt", 3'b000, 3'b000, 3'b000, 42'd0, 24'd0, 3'b000);
  endtask

  function automatic logic [41:0] ad3(input int a2, input int a1, input int a0);
    return {14'(a2), 14'(a1), 14'(a0)};
  endfunction

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  we;
    logic [2:0]  lock;
    logic [41:0] addr;
    logic [23:0] wdata;
    logic [2:0]  gnt;
  } vec_t;

  vec_t tv[12];

  initial begin
    // Round-robin from reset (ptr = NREQ-1), single read, write/read, mixed traffic.
    tv[0]  = '{3'b111, 3'b000, 3'b000, ad3(30, 20, 10), 24'd0, 3'b001};
    tv[1]  = '{3'b111, 3'b000, 3'b000, ad3(30, 20, 10), 24'd0, 3'b010};
    tv[2]  = '{3'b111, 3'b000, 3'b000, ad3(30, 20, 10), 24'd0, 3'b100};
    tv[3]  = '{3'b111, 3'b000, 3'b000, ad3(30, 20, 10), 24'd0, 3'b001};
    tv[4]  = '{3'b000, 3'b000, 3'b000, ad3(0, 0, 0), 24'd0, 3'b000};
    tv[5]  = '{3'b001, 3'b000, 3'b000, ad3(0, 0, 130), 24'd0, 3'b001};
    tv[6]  = '{3'b000, 3'b000, 3'b000, ad3(0, 0, 0), 24'd0, 3'b000};
    tv[7]  = '{3'b100, 3'b100, 3'b000, ad3(16383, 0, 0), 24'h2A0000, 3'b100};
    tv[8]  = '{3'b100, 3'b000, 3'b000, ad3(16383, 0, 0), 24'd0, 3'b100};
    tv[9]  = '{3'b011, 3'b010, 3'b000, ad3(0, 20, 5), 24'h007700, 3'b001};
    tv[10] = '{3'b010, 3'b010, 3'b000, ad3(0, 20, 5), 24'h007700, 3'b010};
    tv[11] = '{3'b001, 3'b000, 3'b000, ad3(0, 0, 20), 24'd0, 3'b001};

    #2;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_outs", {res_rd, res_wr, rvalid, res_addr, res_do, rdata}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      step($sformatf("vec%0d_gnt", i), tv[i].req, tv[i].we, tv[i].lock, tv[i].addr,
           tv[i].wdata, tv[i].gnt);
    end
    idle(3);

    // Lock burst: requester 1 keeps 8 consecutive grants with requester 0 waiting.
    step("lock_first", 3'b010, 3'b000, 3'b010, ad3(0, 40, 50), 24'd0, 3'b010);
    for (int i = 0; i < 7; i++) begin
      step("lock_hold", 3'b011, 3'b000, 3'b010, ad3(0, 40, 50), 24'd0, 3'b010);
    end
    step("lock_release", 3'b011, 3'b000, 3'b010, ad3(0, 40, 50), 24'd0, 3'b001);
    idle(3);
    check("drain_cmd", 32'(cmd_q.size()), 32'd0);
    check("drain_rsp", 32'(rsp_q.size()), 32'd0);

    // Reset while a read command is on the memory pins.
    step("pre_rst_gnt", 3'b001, 3'b000, 3'b000, ad3(0, 0, 130), 24'd0, 3'b001);
    req = '0;
    check("inflight_rd", 32'(res_rd), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_outs", {res_rd, res_wr, rvalid, res_addr, res_do, rdata}, 32'd0);
    cmd_q.delete();
    rsp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_rvalid", 32'(rvalid), 32'd0);
    end
    @(posedge clk);
    #1;
    step("post_rst_gnt", 3'b111, 3'b000, 3'b000, ad3(3, 2, 1), 24'd0, 3'b001);
    idle(3);

`ifdef RES_ARB_STATS_EN
    stat_clr = 1'b1;
    idle(1);
    stat_clr = 1'b0;
    check("stat_clr_grants", 32'(stat_grants), 32'd0);
    step("stat_gnt0", 3'b111, 3'b000, 3'b000, ad3(3, 2, 1), 24'd0, 3'b010);
    step("stat_gnt1", 3'b111, 3'b000, 3'b000, ad3(3, 2, 1), 24'd0, 3'b100);
    step("stat_gnt2", 3'b111, 3'b000, 3'b000, ad3(3, 2, 1), 24'd0, 3'b001);
    step("stat_gnt3", 3'b111, 3'b000, 3'b000, ad3(3, 2, 1), 24'd0, 3'b010);
    req = '0;
    check("stat_grants", 32'(stat_grants), 32'd4);
    check("stat_stall", 32'(stat_stall), 32'd4);
    stat_clr = 1'b1;
    idle(1);
    stat_clr = 1'b0;
    check("stat_clr2", {stat_grants, stat_stall}, 32'd0);
    idle(3);
`endif

    check("final_cmd_q", 32'(cmd_q.size()), 32'd0);
    check("final_rsp_q", 32'(rsp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
